// File: rtl/cs_pkg.sv
// Shared types and cyclic-shift helpers for the (K, K+1) cyclic-shift erasure decoder.
package cs_pkg;

   localparam int unsigned MAX_W  = 64;
   localparam int unsigned MAX_IW = 6;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_RESOLVE = 2'd1,
      ST_EMIT    = 2'd2
   } state_e;

   // Rotate right within the low w bits: result bit j = v[(j+n) mod w].
   function automatic logic [MAX_W-1:0] rot_r(input logic [MAX_W-1:0] v,
                                              input int unsigned n,
                                              input int unsigned w);
      logic [MAX_W-1:0] r;
      r = '0;
      for (int unsigned j = 0; j < MAX_W; j++) begin
         if (j < w) r[MAX_IW'(j)] = v[MAX_IW'((j + n) % w)];
      end
      return r;
   endfunction

   function automatic int unsigned shift_of(input int unsigned i, input int unsigned w);
      return (i + 1) % w;
   endfunction

   function automatic int unsigned inv_shift(input int unsigned n, input int unsigned w);
      return (w - n) % w;
   endfunction

endpackage

// File: rtl/cs_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module cs_sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) count_d = count_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/cs_stream_decoder.sv
// Streaming single-parity cyclic-shift erasure decoder: buffers one K+1 frame,
// rebuilds at most one erased data symbol, then replays the K data symbols.
module cs_stream_decoder
   import cs_pkg::*;
#(
   parameter int unsigned K     = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_sym,
   input  logic             in_erased,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sym,
   output logic             out_last,
   output logic             out_ok,
   output logic [CNT_W-1:0] cnt_recovered,
   output logic [CNT_W-1:0] cnt_failed
);

   localparam int unsigned IDX_W  = $clog2(K + 1);
   localparam int unsigned OIDX_W = $clog2(K);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [1:0]         ecnt_q, ecnt_d;
   logic [OIDX_W-1:0]  e_idx_q, e_idx_d;
   logic               perr_q, perr_d;
   logic               malf_q, malf_d;
   logic [WIDTH-1:0]   sym_buf_q [K];
   logic [WIDTH-1:0]   sym_buf_d [K];
   logic [OIDX_W-1:0]  oidx_q, oidx_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   out_sym_q, out_sym_d;
   logic               out_last_q, out_last_d;
   logic               out_ok_q, out_ok_d;
   logic               inc_rec, inc_fail;
   logic               par_beat;

   assign par_beat = (idx_q == IDX_W'(K));

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      ecnt_d      = ecnt_q;
      e_idx_d     = e_idx_q;
      perr_d      = perr_q;
      malf_d      = malf_q;
      sym_buf_d   = sym_buf_q;
      oidx_d      = oidx_q;
      out_valid_d = out_valid_q;
      out_sym_d   = out_sym_q;
      out_last_d  = out_last_q;
      out_ok_d    = out_ok_q;
      inc_rec     = 1'b0;
      inc_fail    = 1'b0;

      case (state_q)
         ST_COLLECT: begin
            if (in_valid) begin
               if (!par_beat) begin
                  sym_buf_d[OIDX_W'(idx_q)] = in_sym;
                  if (in_erased) begin
                     ecnt_d  = (ecnt_q == 2'd2) ? 2'd2 : ecnt_q + 2'd1;
                     e_idx_d = OIDX_W'(idx_q);
                  end else begin
                     acc_d = acc_q ^ WIDTH'(rot_r(MAX_W'(in_sym),
                                                  shift_of(32'(idx_q), WIDTH), WIDTH));
                  end
               end else begin
                  if (in_erased) perr_d = 1'b1;
                  else           acc_d  = acc_q ^ in_sym;
               end
               // Frame closes on in_last or on the parity slot; disagreement means malformed.
               if (in_last || par_beat) begin
                  malf_d  = (in_last != par_beat);
                  state_d = ST_RESOLVE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end

         ST_RESOLVE: begin
            if (!malf_q && (ecnt_q == 2'd0)) begin
               out_ok_d = 1'b1;
            end else if (!malf_q && (ecnt_q == 2'd1) && !perr_q) begin
               sym_buf_d[e_idx_q] = WIDTH'(rot_r(MAX_W'(acc_q),
                                                 inv_shift(shift_of(32'(e_idx_q), WIDTH), WIDTH),
                                                 WIDTH));
               out_ok_d = 1'b1;
               inc_rec  = 1'b1;
            end else begin
               for (int i = 0; i < K; i++) sym_buf_d[i] = '0;
               out_ok_d = 1'b0;
               inc_fail = 1'b1;
            end
            oidx_d      = '0;
            out_valid_d = 1'b1;
            out_sym_d   = sym_buf_d[0];
            out_last_d  = 1'b0;
            state_d     = ST_EMIT;
         end

         ST_EMIT: begin
            if (out_ready) begin
               if (out_last_q) begin
                  state_d     = ST_COLLECT;
                  out_valid_d = 1'b0;
                  out_sym_d   = '0;
                  out_last_d  = 1'b0;
                  out_ok_d    = 1'b0;
                  oidx_d      = '0;
                  idx_d       = '0;
                  acc_d       = '0;
                  ecnt_d      = '0;
                  e_idx_d     = '0;
                  perr_d      = 1'b0;
                  malf_d      = 1'b0;
               end else begin
                  oidx_d     = oidx_q + OIDX_W'(1);
                  out_sym_d  = sym_buf_q[oidx_d];
                  out_last_d = (oidx_d == OIDX_W'(K - 1));
               end
            end
         end

         default: state_d = ST_COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_COLLECT;
         idx_q       <= '0;
         acc_q       <= '0;
         ecnt_q      <= '0;
         e_idx_q     <= '0;
         perr_q      <= 1'b0;
         malf_q      <= 1'b0;
         for (int i = 0; i < K; i++) sym_buf_q[i] <= '0;
         oidx_q      <= '0;
         out_valid_q <= 1'b0;
         out_sym_q   <= '0;
         out_last_q  <= 1'b0;
         out_ok_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         ecnt_q      <= ecnt_d;
         e_idx_q     <= e_idx_d;
         perr_q      <= perr_d;
         malf_q      <= malf_d;
         sym_buf_q   <= sym_buf_d;
         oidx_q      <= oidx_d;
         out_valid_q <= out_valid_d;
         out_sym_q   <= out_sym_d;
         out_last_q  <= out_last_d;
         out_ok_q    <= out_ok_d;
      end
   end

   assign in_ready  = rst_n & (state_q == ST_COLLECT);
   assign out_valid = out_valid_q;
   assign out_sym   = out_sym_q;
   assign out_last  = out_last_q;
   assign out_ok    = out_ok_q;

   cs_sat_counter #(.W(CNT_W)) u_cnt_rec (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc_rec),
      .count (cnt_recovered)
   );

   cs_sat_counter #(.W(CNT_W)) u_cnt_fail (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc_fail),
      .count (cnt_failed)
   );

endmodule

// File: tb/tb_cs_stream_decoder.sv
// Bench: two decoder instances (K=2/W=4/CNT_W=2 and defaults) checked against a frame-level model.
module tb_cs_stream_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, cur;
   logic       in_valid, in_erased, in_last;
   logic       out_ready = 1'b1;
   logic [7:0] in_sym;

   logic       in_valid_a, in_ready_a, out_valid_a, out_last_a, out_ok_a;
   logic [3:0] in_sym_a, out_sym_a;
   logic [1:0] crec_a, cfail_a;
   logic        in_valid_b, in_ready_b, out_valid_b, out_last_b, out_ok_b;
   logic [7:0]  out_sym_b;
   logic [15:0] crec_b, cfail_b;

   assign in_valid_a = in_valid & ~cur;
   assign in_valid_b = in_valid & cur;
   assign in_sym_a   = in_sym[3:0];

   cs_stream_decoder #(.K(2), .WIDTH(4), .CNT_W(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_sym(in_sym_a), .in_erased(in_erased), .in_last(in_last),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_sym(out_sym_a),
      .out_last(out_last_a), .out_ok(out_ok_a),
      .cnt_recovered(crec_a), .cnt_failed(cfail_a));

   cs_stream_decoder dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_sym(in_sym), .in_erased(in_erased), .in_last(in_last),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_sym(out_sym_b),
      .out_last(out_last_b), .out_ok(out_ok_b),
      .cnt_recovered(crec_b), .cnt_failed(cfail_b));

   logic        ir, ov, ol, ook;
   logic [7:0]  os;
   logic [15:0] crec, cfail;
   assign ir    = cur ? in_ready_b  : in_ready_a;
   assign ov    = cur ? out_valid_b : out_valid_a;
   assign ol    = cur ? out_last_b  : out_last_a;
   assign ook   = cur ? out_ok_b    : out_ok_a;
   assign os    = cur ? out_sym_b   : {4'h0, out_sym_a};
   assign crec  = cur ? crec_b      : {14'h0, crec_a};
   assign cfail = cur ? cfail_b     : {14'h0, cfail_a};

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- frame-level model ----------------
   typedef struct packed {
      logic [7:0] sym;
      logic       last;
      logic       ok;
   } exp_t;

   exp_t       expq[$];
   logic [7:0] fd [16];
   int         m_rec, m_fail;
   int         last_present_cyc = 0;
   int         rise_cyc = -100;
   logic       rdy_rand;

   function automatic int kk();   return cur ? 4 : 2;      endfunction
   function automatic int ww();   return cur ? 8 : 4;      endfunction
   function automatic int cmax(); return cur ? 65535 : 3;  endfunction

   function automatic logic [7:0] m_rot(input logic [7:0] v, input int n, input int w);
      logic [7:0] r = '0;
      for (int j = 0; j < w; j++) r[3'(j)] = v[3'((j + n) % w)];
      return r;
   endfunction

   function automatic logic [7:0] parity_of();
      logic [7:0] p = '0;
      for (int i = 0; i < kk(); i++) p ^= m_rot(fd[i], (i + 1) % ww(), ww());
      return p;
   endfunction

   task automatic wait_ready();
      int t = 0;
      while (!ir && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("in_ready_wait", 32'(ir), 32'd1);
   endtask

   // Erased data comes back as sent when decodable, otherwise the frame is all zeros.
   task automatic send_frame(input int er_mask, input int last_at);
      int k, w, nb, de;
      logic pe, malf, dec, er;
      logic [7:0] p, mask;
      exp_t e;
      k = kk(); w = ww();
      mask = 8'((1 << w) - 1);
      p = parity_of();
      nb = (last_at >= 0 && last_at < k) ? last_at + 1 : k + 1;
      malf = (last_at != k);
      de = 0;
      for (int i = 0; i < k && i < nb; i++) if (((er_mask >> i) & 1) != 0) de++;
      pe  = (nb == k + 1) && (((er_mask >> k) & 1) != 0);
      dec = !malf && (de == 0 || (de == 1 && !pe));
      for (int i = 0; i < k; i++) begin
         e.sym  = dec ? fd[i] : 8'h00;
         e.last = (i == k - 1);
         e.ok   = dec;
         expq.push_back(e);
      end
      if (dec && de == 1 && m_rec < cmax()) m_rec++;
      if (!dec && m_fail < cmax()) m_fail++;
      for (int b = 0; b < nb; b++) begin
         er        = ((er_mask >> b) & 1) != 0;
         in_valid  = 1'b1;
         in_erased = er;
         in_last   = (b == last_at);
         in_sym    = er ? (8'($urandom) & mask) : ((b < k) ? fd[b] : p);
         wait_ready();
         last_present_cyc = cyc;
         @(negedge clk);
      end
      // Junk held on the input during replay must never be consumed.
      in_sym    = 8'($urandom) & mask;
      in_erased = 1'($urandom);
      in_last   = 1'($urandom);
      wait_ready();
      chk("first_valid_latency", 32'(rise_cyc - last_present_cyc), 32'd2);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- per-cycle output compare ----------------
   logic       prev_ov = 1'b0;
   logic       hold_pending = 1'b0;
   logic [7:0] hold_sym;
   logic       hold_last, hold_ok;

   always @(negedge clk) begin
      exp_t e;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!rst_n) begin
         prev_ov      = 1'b0;
         hold_pending = 1'b0;
      end else begin
         if (ov && !prev_ov) begin
            rise_cyc = cyc;
            chk("cnt_recovered", 32'(crec), 32'(m_rec));
            chk("cnt_failed", 32'(cfail), 32'(m_fail));
         end
         if (ov) chk("in_ready_low_during_emit", 32'(ir), 32'd0);
         if (ov && hold_pending) begin
            chk("hold_sym", 32'(os), 32'(hold_sym));
            chk("hold_last", 32'(ol), 32'(hold_last));
            chk("hold_ok", 32'(ook), 32'(hold_ok));
         end
         if (ov && out_ready) begin
            chk("beat_expected", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) begin
               e = expq.pop_front();
               chk("out_sym", 32'(os), 32'(e.sym));
               chk("out_last", 32'(ol), 32'(e.last));
               chk("out_ok", 32'(ook), 32'(e.ok));
            end
            hold_pending = 1'b0;
         end else if (ov) begin
            hold_pending = 1'b1;
            hold_sym     = os;
            hold_last    = ol;
            hold_ok      = ook;
         end
         prev_ov = ov;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int r, m, l, a, b;
      rst_n = 1'b0; cur = 1'b0; rdy_rand = 1'b0;
      in_valid = 1'b0; in_erased = 1'b0; in_last = 1'b0; in_sym = '0;
      m_rec = 0; m_fail = 0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready_a", 32'(in_ready_a), 32'd0);
      chk("rst_out_valid_a", 32'(out_valid_a), 32'd0);
      chk("rst_out_sym_a", 32'(out_sym_a), 32'd0);
      chk("rst_out_last_a", 32'(out_last_a), 32'd0);
      chk("rst_out_ok_a", 32'(out_ok_a), 32'd0);
      chk("rst_cnt_a", 32'({crec_a, cfail_a}), 32'd0);
      chk("rst_in_ready_b", 32'(in_ready_b), 32'd0);
      chk("rst_out_valid_b", 32'(out_valid_b), 32'd0);
      chk("rst_cnt_b", 32'({crec_b, cfail_b}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // K=2, WIDTH=4 hand frame {3, 5, C}
      fd[0] = 8'h3; fd[1] = 8'h5;
      chk("model_parity_pin", 32'(parity_of()), 32'h0C);
      send_frame(0, 2);
      chk("hand_rec_none", 32'(crec), 32'd0);
      send_frame(1, 2);
      chk("hand_rec_d0", 32'(crec), 32'd1);
      send_frame(2, 2);
      chk("hand_rec_d1", 32'(crec), 32'd2);

      // Four failing frames on a 2-bit counter
      send_frame(32'b101, 2);
      send_frame(0, 0);
      send_frame(0, -1);
      send_frame(32'b011, 2);
      chk("fail_saturates", 32'(cfail), 32'd3);
      chk("rec_untouched", 32'(crec), 32'd2);

      idle();
      cur = 1'b1; m_rec = 0; m_fail = 0;
      @(negedge clk);

      // Defaults: erase each data index, then the parity alone
      for (int e = 0; e <= 4; e++) begin
         for (int i = 0; i < 16; i++) fd[i] = 8'($urandom);
         send_frame(1 << e, 4);
      end
      chk("rec_each_index", 32'(crec), 32'd4);
      chk("fail_none", 32'(cfail), 32'd0);
      send_frame(32'b10001, 4);
      chk("fail_d0_parity", 32'(cfail), 32'd1);
      send_frame(0, 2);
      chk("fail_early_last", 32'(cfail), 32'd2);

      // Random frames with random output backpressure
      rdy_rand = 1'b1;
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < 16; i++) fd[i] = 8'($urandom);
         r = $urandom_range(0, 5);
         l = 4;
         case (r)
            0: m = 0;
            1: m = 1 << $urandom_range(0, 3);
            2: m = 16;
            3: begin
               a = $urandom_range(0, 3);
               b = (a + 1 + $urandom_range(0, 2)) % 4;
               m = (1 << a) | (1 << b);
            end
            4: m = (1 << $urandom_range(0, 3)) | 16;
            default: begin
               m = $urandom_range(0, 31);
               l = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : -1;
            end
         endcase
         send_frame(m, l);
      end
      rdy_rand = 1'b0;

      // Reset mid-frame, then a fresh frame
      in_valid = 1'b1; in_erased = 1'b0; in_last = 1'b0;
      in_sym = fd[0];
      wait_ready();
      @(negedge clk);
      in_sym = fd[1];
      wait_ready();
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("mid_rst_in_ready", 32'(ir), 32'd0);
      chk("mid_rst_out_valid", 32'(ov), 32'd0);
      chk("mid_rst_out_sym", 32'(os), 32'd0);
      chk("mid_rst_out_last", 32'(ol), 32'd0);
      chk("mid_rst_out_ok", 32'(ook), 32'd0);
      chk("mid_rst_cnt_rec", 32'(crec), 32'd0);
      chk("mid_rst_cnt_fail", 32'(cfail), 32'd0);
      m_rec = 0; m_fail = 0;
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 16; i++) fd[i] = 8'($urandom);
      send_frame(1 << 2, 4);
      chk("post_reset_rec", 32'(crec), 32'd1);

      idle();
      chk("queue_drained", 32'(expq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cs_stream_decoder.md
# cs_stream_decoder

Streaming, parametrised single-parity cyclic-shift erasure decoder, the (K, K+1) generalisation of the fixed (2, 3) decoder. Symbols arrive serially, one per beat, with a per-symbol erasure flag. Each K-data + 1-parity frame is buffered, at most one erased data symbol is recovered, and the K data symbols are replayed serially with valid/ready backpressure. It sits between the erasure-marking receive path and the payload sink, and keeps saturating recovery/failure statistics.

## Interface
- K, 4, data symbols per frame (2..16)
- WIDTH, 8, symbol width in bits (≥2); data symbol i is coded with shift S(i) = (i+1) mod WIDTH, parity with shift 0
- CNT_W, 16, statistics counter width
- clk  in  1  clock; one clock domain
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_sym  in  WIDTH  received symbol
- in_erased  in  1  symbol is an erasure (content ignored)
- in_last  in  1  final beat of the frame (the parity beat)
- out_valid  out  1  output beat valid
- out_ready  in  1  sink accepts the beat
- out_sym  out  WIDTH  recovered data symbol
- out_last  out  1  beat K-1 of the frame
- out_ok  out  1  frame decoded correctly; constant for the whole frame
- cnt_recovered  out  CNT_W  frames in which one data symbol was rebuilt, saturating
- cnt_failed  out  CNT_W  undecodable or malformed frames, saturating

## Operation
- rot_r(v, n): result bit j = v[(j+n) mod WIDTH]. Encoding: p = XOR over i of rot_r(d_i, S(i)).
- FSM states COLLECT, RESOLVE, EMIT; reset state COLLECT.
- COLLECT:
  - in_ready = 1; beat index idx counts 0..K.
  - Accepted data beat (idx<K) stores in_sym into buf[idx].
  - If the data beat is not erased: acc ^= rot_r(in_sym, S(idx)). If erased: erasure count +1 and e_idx = idx.
  - Parity beat (idx=K), not erased: acc ^= in_sym. Erased: sets the parity-erased flag.
  - The frame ends on the first beat with in_last=1 or idx=K. If the two do not coincide, the malformed flag is set. Go to RESOLVE.
- RESOLVE (one cycle, in_ready=0):
  - Not malformed, no data erasure (parity erased or not): ok=1.
  - Not malformed, exactly one data erasure and parity not erased: buf[e_idx] = rot_r(acc, (WIDTH−S(e_idx)) mod WIDTH), ok=1, cnt_recovered +1.
  - Otherwise: ok=0, all buf cleared to 0, cnt_failed +1.
- EMIT (in_ready=0):
  - out_sym = buf[oidx], out_valid=1, out_last = (oidx==K−1). oidx advances on out_valid&&out_ready.
  - After the out_last handshake: return to COLLECT, clear acc/counts/flags.
- Counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- While rst_n=0 at a clock edge: state=COLLECT, in_ready=0 (gated by rst_n), out_valid=0, out_sym=0, out_last=0, out_ok=0, counters=0, acc=0, idx=0.
- Parity/in_last beat accepted at cycle t: RESOLVE at t+1, first out_valid at t+2.
- out_sym/out_valid/out_last/out_ok are registered and hold stable while out_valid=1 and out_ready=0.
- in_ready rises in the cycle after the final output handshake. There is no input/output overlap; minimum frame period is 2K+2 cycles.
- in_valid while in_ready=0 is ignored and not consumed.
- Reset asserted mid-frame or mid-EMIT discards the frame and does not change counters beyond clearing them.
- Counter increments are visible in the cycle after RESOLVE.

## Structure
- Package cs_pkg holds:
  - the state enum type
  - function rot_r(v, n)
  - function shift_of(i, WIDTH) = (i+1) mod WIDTH
  - function inv_shift(n, WIDTH) = (WIDTH−n) mod WIDTH
- The two statistics counters use sub-module cs_sat_counter (parameter W, inputs clk, rst_n, inc; output count).
- Everything else stays in a single module; buf is a K×WIDTH register array.

## Test plan
- K=2, WIDTH=4, frame {3, 5, C}, no erasures, out_ready=1 → out 3, 5; out_ok=1, out_last on beat 2; first out_valid 2 cycles after the parity beat; counters unchanged.
- Same frame with d0 erased (garbage F) → out 3, 5; out_ok=1; cnt_recovered=1. With d1 erased instead → out 3, 5; cnt_recovered=2.
- Defaults (K=4, WIDTH=8), random data, erase each index 0..3 in turn and then the parity → all data correct; cnt_recovered=4; parity-only erasure not counted.
- Two erasures (d0 and parity) → out 0, 0, 0, 0; out_ok=0; cnt_failed=1. in_last on beat 2 (early) → 4 zero beats, out_ok=0, cnt_failed +1.
- out_ready toggled randomly during EMIT, in_valid held high throughout → no output beat lost or duplicated; in_ready=0 until the final output handshake; no input consumed meanwhile.
- CNT_W=2, 4 failed frames → cnt_failed sticks at 3. rst_n pulsed mid-frame → all outputs 0 the next cycle; a fresh frame then decodes correctly.
